// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the custom AXI IP blocks: controller status and job error codes.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_ZERO_ITER = 2'd1,
    ERR_ABORT     = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } err_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 8;

endpackage

// File: rtl/custom_axi_ip_addsat.sv
// Combinational adder with carry-out; with CUSTOM_AXI_IP_SAT_EN the sum clamps to all-ones on carry.
module custom_axi_ip_addsat #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry
);

  logic [DATA_WIDTH:0] raw;

  assign raw   = {1'b0, a} + {1'b0, b};
  assign carry = raw[DATA_WIDTH];

`ifdef CUSTOM_AXI_IP_SAT_EN
  assign sum = carry ? {DATA_WIDTH{1'b1}} : raw[DATA_WIDTH-1:0];
`else
  assign sum = raw[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/custom_axi_ip_accum.sv
// Accumulate engine: seed + step repeated iter times, valid/ack result handshake.
// CUSTOM_AXI_IP_SAT_EN selects saturating adds (with sat_o) instead of an overflow error.
module custom_axi_ip_accum
  import custom_axi_ip_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  input  logic [CNT_WIDTH-1:0]  iter_i,
  input  logic                  abort_i,
  input  logic                  ack_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  iter_cnt_o,
  output err_e                  err_o,
`ifdef CUSTOM_AXI_IP_SAT_EN
  output logic                  sat_o,
`endif
  output status_e               status_o
);

  status_e               state, state_next;
  err_e                  err, err_next;
  logic [DATA_WIDTH-1:0] acc, acc_next;
  logic [DATA_WIDTH-1:0] step, step_next;
  logic [DATA_WIDTH-1:0] result, result_next;
  logic [CNT_WIDTH-1:0]  iter, iter_next;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;
`ifdef CUSTOM_AXI_IP_SAT_EN
  logic                  sat, sat_next;
`endif

  custom_axi_ip_addsat #(.DATA_WIDTH(DATA_WIDTH)) u_addsat (
    .a     (acc),
    .b     (step),
    .sum   (sum),
    .carry (carry)
  );

  always_comb begin
    state_next  = state;
    err_next    = err;
    acc_next    = acc;
    step_next   = step;
    result_next = result;
    iter_next   = iter;
    cnt_next    = cnt;
`ifdef CUSTOM_AXI_IP_SAT_EN
    sat_next    = sat;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
          cnt_next = '0;
`ifdef CUSTOM_AXI_IP_SAT_EN
          sat_next = 1'b0;
`endif
          if (iter_i == '0) begin
            state_next = ERROR;
            err_next   = ERR_ZERO_ITER;
          end else begin
            acc_next   = seed_i;
            step_next  = step_i;
            iter_next  = iter_i;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // Abort is checked first so it beats both completion and overflow.
        if (abort_i) begin
          state_next = ERROR;
          err_next   = ERR_ABORT;
        end else if (cnt == iter) begin
          state_next  = DONE;
          result_next = acc;
        end else begin
          acc_next = sum;
          cnt_next = cnt + CNT_WIDTH'(1);
`ifdef CUSTOM_AXI_IP_SAT_EN
          if (carry) sat_next = 1'b1;
`else
          if (carry) begin
            state_next  = ERROR;
            err_next    = ERR_OVERFLOW;
            result_next = '0;
          end
`endif
        end
      end
      DONE: begin
        if (ack_i) state_next = IDLE;
      end
      ERROR: begin
        if (ack_i) begin
          state_next = IDLE;
          err_next   = ERR_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      err    <= ERR_NONE;
      acc    <= '0;
      step   <= '0;
      result <= '0;
      iter   <= '0;
      cnt    <= '0;
`ifdef CUSTOM_AXI_IP_SAT_EN
      sat    <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      err    <= err_next;
      acc    <= acc_next;
      step   <= step_next;
      result <= result_next;
      iter   <= iter_next;
      cnt    <= cnt_next;
`ifdef CUSTOM_AXI_IP_SAT_EN
      sat    <= sat_next;
`endif
    end
  end

  assign status_o   = state;
  assign busy_o     = (state == BUSY);
  assign valid_o    = (state == DONE);
  assign err_o      = err;
  assign result_o   = result;
  assign iter_cnt_o = cnt;
`ifdef CUSTOM_AXI_IP_SAT_EN
  assign sat_o      = sat;
`endif

endmodule
